// File: rtl/branch_predict_unit.sv
// branch_predict_unit
// Direct-mapped BTB with 2-bit saturating counters. The IF port looks up
// if_pc. The ID port resolves B / B.LT / CBZ, flags mispredicts, and trains
// the table on the clock edge.
// Optional build macro: BRPRED_STATS_EN adds branch/mispredict counters.
module branch_predict_unit #(
   parameter int WIDTH    = 64,
   parameter int ENTRIES  = 16,
   parameter int IDX_BITS = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] if_pc,
   output logic             pred_taken,
   output logic [WIDTH-1:0] pred_target,
   input  logic             id_valid,
   input  logic [WIDTH-1:0] id_pc,
   input  logic [3:0]       id_opcode,
   input  logic [WIDTH-1:0] id_db,
   input  logic             id_n,
   input  logic             id_o,
   input  logic [18:0]      id_imm19,
   input  logic [25:0]      id_imm26,
   input  logic             id_pred_taken,
   input  logic [WIDTH-1:0] id_pred_target,
   output logic             br_taken,
   output logic             redirect,
   output logic [WIDTH-1:0] redirect_pc
`ifdef BRPRED_STATS_EN
   ,
   output logic [31:0]      stat_branches,
   output logic [31:0]      stat_mispredicts
`endif
);

   localparam int TAG_W = WIDTH - IDX_BITS - 2;
   localparam logic [3:0] OP_BLT = 4'd3;
   localparam logic [3:0] OP_B   = 4'd4;
   localparam logic [3:0] OP_CBZ = 4'd5;
   localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

   // Counter moves saturate at the ends of the 2-bit range.
   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == 2'b11) ? 2'b11 : c + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == 2'b00) ? 2'b00 : c - 2'd1;
   endfunction

   // Table storage: valid/ctr are control state and get reset; tag/target are
   // data and are only meaningful under a set valid bit.
   logic             tbl_valid  [ENTRIES];
   logic [1:0]       tbl_ctr    [ENTRIES];
   logic [TAG_W-1:0] tbl_tag    [ENTRIES];
   logic [WIDTH-1:0] tbl_target [ENTRIES];

   logic [IDX_BITS-1:0] if_idx, id_idx;
   logic [TAG_W-1:0]    if_tag, id_tag;
   logic                if_hit, id_hit;

   logic                is_b, is_br, taken;
   logic signed [WIDTH-1:0] off19, off26, br_off;
   logic [WIDTH-1:0]    tgt, id_seq_pc;
   logic                unused_pc_bits;

   assign if_idx = if_pc[IDX_BITS+1:2];
   assign if_tag = if_pc[WIDTH-1:IDX_BITS+2];
   assign id_idx = id_pc[IDX_BITS+1:2];
   assign id_tag = id_pc[WIDTH-1:IDX_BITS+2];
   assign unused_pc_bits = ^{if_pc[1:0], id_pc[1:0]};

   // IF lookup: reads pre-update contents, so a same-cycle write shows next cycle.
   always_comb begin
      if_hit      = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);
      pred_taken  = if_hit && tbl_ctr[if_idx][1];
      pred_target = pred_taken ? tbl_target[if_idx] : if_pc + PC_STEP;
   end

   assign off19  = {{(WIDTH-19){id_imm19[18]}}, id_imm19};
   assign off26  = {{(WIDTH-26){id_imm26[25]}}, id_imm26};

   // ID resolve and mispredict detection.
   always_comb begin
      is_b      = (id_opcode == OP_B);
      is_br     = is_b || (id_opcode == OP_BLT) || (id_opcode == OP_CBZ);
      taken     = is_b
                  || ((id_opcode == OP_BLT) && (id_n ^ id_o))
                  || ((id_opcode == OP_CBZ) && (id_db == '0));
      br_off    = is_b ? off26 : off19;
      tgt       = id_pc + $unsigned(br_off <<< 2);
      id_seq_pc = id_pc + PC_STEP;
      id_hit    = tbl_valid[id_idx] && (tbl_tag[id_idx] == id_tag);
      br_taken  = id_valid && taken;
      redirect  = 1'b0;
      if (id_valid) begin
         if (is_br)
            redirect = (taken != id_pred_taken) || (taken && (tgt != id_pred_target));
         else
            redirect = id_pred_taken;
      end
      redirect_pc = taken ? tgt : id_seq_pc;
   end

   // Training of valid bits and counters; reset clears the table at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl_valid[i] <= 1'b0;
            tbl_ctr[i]   <= 2'b01;
         end
      end else if (id_valid) begin
         if (is_br) begin
            if (id_hit)
               tbl_ctr[id_idx] <= taken ? sat_inc(tbl_ctr[id_idx]) : sat_dec(tbl_ctr[id_idx]);
            else if (taken) begin
               tbl_valid[id_idx] <= 1'b1;
               tbl_ctr[id_idx]   <= is_b ? 2'b11 : 2'b10;
            end
         end else if (id_hit) begin
            tbl_valid[id_idx] <= 1'b0;
         end
      end
   end

   // Tag/target capture on every taken branch (allocate or refresh).
   always_ff @(posedge clk) begin
      if (id_valid && is_br && taken) begin
         tbl_tag[id_idx]    <= id_tag;
         tbl_target[id_idx] <= tgt;
      end
   end

`ifdef BRPRED_STATS_EN
   // Event counters for resolved branches and their mispredicts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (id_valid && is_br) begin
         stat_branches <= stat_branches + 32'd1;
         if (redirect)
            stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit (default WIDTH=64, ENTRIES=16).
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] if_pc;
   logic        pred_taken;
   logic [63:0] pred_target;
   logic        id_valid;
   logic [63:0] id_pc;
   logic [3:0]  id_opcode;
   logic [63:0] id_db;
   logic        id_n, id_o;
   logic [18:0] id_imm19;
   logic [25:0] id_imm26;
   logic        id_pred_taken;
   logic [63:0] id_pred_target;
   logic        br_taken, redirect;
   logic [63:0] redirect_pc;
`ifdef BRPRED_STATS_EN
   logic [31:0] stat_branches, stat_mispredicts;
`endif

   int total = 0;
   int bad   = 0;

   branch_predict_unit #(.WIDTH(64), .ENTRIES(16)) dut (
      .clk(clk), .reset(reset), .if_pc(if_pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode), .id_db(id_db),
      .id_n(id_n), .id_o(id_o), .id_imm19(id_imm19), .id_imm26(id_imm26),
      .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
      .br_taken(br_taken), .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef BRPRED_STATS_EN
      , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_id(input logic v, input logic [63:0] pc, input logic [3:0] op,
                           input logic [63:0] db, input logic n, input logic o,
                           input logic [18:0] i19, input logic [25:0] i26,
                           input logic pt, input logic [63:0] ptgt);
      id_valid = v; id_pc = pc; id_opcode = op; id_db = db; id_n = n; id_o = o;
      id_imm19 = i19; id_imm26 = i26; id_pred_taken = pt; id_pred_target = ptgt;
   endtask

   task automatic idle();
      drive_id(1'b0, 64'h0, 4'd0, 64'h1, 1'b0, 1'b0, 19'd0, 26'd0, 1'b0, 64'h0);
   endtask

   task automatic test_reset();
      reset = 1'b1; idle(); if_pc = 64'h40;
      tick(); tick();
      reset = 1'b0;
      #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_taken got=%b exp=0", pred_taken); end
      total++; if (pred_target !== 64'h44) begin bad++; $display("FAIL reset_pred_target got=%h exp=44", pred_target); end
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
      total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL reset_br_taken got=%b exp=0", br_taken); end
`ifdef BRPRED_STATS_EN
      total++; if (stat_branches !== 32'd0) begin bad++; $display("FAIL reset_stat_br got=%0d exp=0", stat_branches); end
`endif
   endtask

   task automatic test_cbz_alloc();
      if_pc = 64'h100;
      drive_id(1'b1, 64'h100, 4'd5, 64'h0, 1'b0, 1'b0, 19'd4, 26'd0, 1'b0, 64'h0);
      #1;
      total++; if (br_taken !== 1'b1) begin bad++; $display("FAIL cbz_br_taken got=%b exp=1", br_taken); end
      total++; if (redirect !== 1'b1) begin bad++; $display("FAIL cbz_redirect got=%b exp=1", redirect); end
      total++; if (redirect_pc !== 64'h110) begin bad++; $display("FAIL cbz_redirect_pc got=%h exp=110", redirect_pc); end
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL cbz_same_cycle_pred got=%b exp=0", pred_taken); end
      tick(); idle(); #1;
      total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL cbz_next_pred got=%b exp=1", pred_taken); end
      total++; if (pred_target !== 64'h110) begin bad++; $display("FAIL cbz_next_target got=%h exp=110", pred_target); end
   endtask

   task automatic test_training();
      // ctr 10 -> not taken -> 01
      if_pc = 64'h100;
      drive_id(1'b1, 64'h100, 4'd5, 64'h1, 1'b0, 1'b0, 19'd4, 26'd0, 1'b1, 64'h110);
      #1;
      total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL trn_nt_br_taken got=%b exp=0", br_taken); end
      total++; if (redirect !== 1'b1) begin bad++; $display("FAIL trn_nt_redirect got=%b exp=1", redirect); end
      total++; if (redirect_pc !== 64'h104) begin bad++; $display("FAIL trn_nt_redirect_pc got=%h exp=104", redirect_pc); end
      tick(); idle(); #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL trn_ctr01_pred got=%b exp=0", pred_taken); end
      total++; if (pred_target !== 64'h104) begin bad++; $display("FAIL trn_ctr01_target got=%h exp=104", pred_target); end
      // two more not-taken: 00, then saturated at 00
      drive_id(1'b1, 64'h100, 4'd5, 64'h1, 1'b0, 1'b0, 19'd4, 26'd0, 1'b0, 64'h0);
      #1;
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL trn_nt_correct_redirect got=%b exp=0", redirect); end
      tick(); tick();
      // one taken: 00 -> 01, still not taken
      drive_id(1'b1, 64'h100, 4'd5, 64'h0, 1'b0, 1'b0, 19'd4, 26'd0, 1'b0, 64'h0);
      tick(); idle(); #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL trn_sat_pred got=%b exp=0", pred_taken); end
      // second taken: 01 -> 10, predicts taken again
      drive_id(1'b1, 64'h100, 4'd5, 64'h0, 1'b0, 1'b0, 19'd4, 26'd0, 1'b0, 64'h0);
      tick(); idle(); #1;
      total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL trn_ctr10_pred got=%b exp=1", pred_taken); end
      total++; if (pred_target !== 64'h110) begin bad++; $display("FAIL trn_ctr10_target got=%h exp=110", pred_target); end
   endtask

   task automatic test_backward();
      if_pc = 64'h200;
      drive_id(1'b1, 64'h200, 4'd3, 64'h5, 1'b1, 1'b0, 19'h7FFFF, 26'd0, 1'b0, 64'h0);
      #1;
      total++; if (br_taken !== 1'b1) begin bad++; $display("FAIL blt_br_taken got=%b exp=1", br_taken); end
      total++; if (redirect_pc !== 64'h1FC) begin bad++; $display("FAIL blt_redirect_pc got=%h exp=1fc", redirect_pc); end
      tick(); idle(); #1;
      total++; if (pred_target !== 64'h1FC) begin bad++; $display("FAIL blt_pred_target got=%h exp=1fc", pred_target); end
      drive_id(1'b1, 64'h200, 4'd3, 64'h5, 1'b1, 1'b1, 19'h7FFFF, 26'd0, 1'b1, 64'h1FC);
      #1;
      total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL blt_nt_br_taken got=%b exp=0", br_taken); end
      total++; if (redirect !== 1'b1) begin bad++; $display("FAIL blt_nt_redirect got=%b exp=1", redirect); end
      total++; if (redirect_pc !== 64'h204) begin bad++; $display("FAIL blt_nt_redirect_pc got=%h exp=204", redirect_pc); end
      tick(); idle();
   endtask

   task automatic test_uncond();
      // B at 0x1000 with imm26 = -2 -> 0xFF8; correctly predicted
      if_pc = 64'h1000;
      drive_id(1'b1, 64'h1000, 4'd4, 64'h5, 1'b0, 1'b0, 19'd0, 26'h3FFFFFE, 1'b1, 64'hFF8);
      #1;
      total++; if (br_taken !== 1'b1) begin bad++; $display("FAIL b_br_taken got=%b exp=1", br_taken); end
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL b_correct_redirect got=%b exp=0", redirect); end
      tick(); idle(); #1;
      total++; if (pred_target !== 64'hFF8) begin bad++; $display("FAIL b_pred_target got=%h exp=ff8", pred_target); end
      // right direction, wrong target
      drive_id(1'b1, 64'h1000, 4'd4, 64'h5, 1'b0, 1'b0, 19'd0, 26'h3FFFFFE, 1'b1, 64'h2000);
      #1;
      total++; if (redirect !== 1'b1) begin bad++; $display("FAIL b_tgt_redirect got=%b exp=1", redirect); end
      total++; if (redirect_pc !== 64'hFF8) begin bad++; $display("FAIL b_tgt_redirect_pc got=%h exp=ff8", redirect_pc); end
      tick(); idle();
   endtask

   task automatic test_id_invalid();
      if_pc = 64'h400;
      drive_id(1'b0, 64'h400, 4'd5, 64'h0, 1'b0, 1'b0, 19'd4, 26'd0, 1'b0, 64'h0);
      #1;
      total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL inv_br_taken got=%b exp=0", br_taken); end
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL inv_redirect got=%b exp=0", redirect); end
      tick(); idle(); #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL inv_no_train got=%b exp=0", pred_taken); end
   endtask

   task automatic test_wrap();
      if_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      #1;
      total++; if (pred_target !== 64'h0) begin bad++; $display("FAIL wrap_if_target got=%h exp=0", pred_target); end
      drive_id(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 4'd5, 64'h1, 1'b0, 1'b0, 19'd1, 26'd0, 1'b1, 64'h0);
      #1;
      total++; if (redirect_pc !== 64'h0) begin bad++; $display("FAIL wrap_seq_pc got=%h exp=0", redirect_pc); end
      drive_id(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 4'd5, 64'h0, 1'b0, 1'b0, 19'd1, 26'd0, 1'b1, 64'h0);
      #1;
      total++; if (redirect !== 1'b0) begin bad++; $display("FAIL wrap_tgt_redirect got=%b exp=0", redirect); end
      tick(); idle();
   endtask

   task automatic test_alias();
      if_pc = 64'h100;
      drive_id(1'b1, 64'h100, 4'd5, 64'h0, 1'b0, 1'b0, 19'd4, 26'd0, 1'b0, 64'h0);
      tick(); idle(); #1;
      total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alias_trained got=%b exp=1", pred_taken); end
      drive_id(1'b1, 64'h100, 4'd1, 64'h0, 1'b0, 1'b0, 19'd4, 26'd0, 1'b1, 64'h110);
      #1;
      total++; if (redirect !== 1'b1) begin bad++; $display("FAIL alias_redirect got=%b exp=1", redirect); end
      total++; if (redirect_pc !== 64'h104) begin bad++; $display("FAIL alias_redirect_pc got=%h exp=104", redirect_pc); end
      total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL alias_br_taken got=%b exp=0", br_taken); end
      tick(); idle(); #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_invalidated got=%b exp=0", pred_taken); end
      // re-train 0x100, then evict it with 0x140 (same index)
      drive_id(1'b1, 64'h100, 4'd5, 64'h0, 1'b0, 1'b0, 19'd4, 26'd0, 1'b0, 64'h0);
      tick();
      drive_id(1'b1, 64'h140, 4'd5, 64'h0, 1'b0, 1'b0, 19'd2, 26'd0, 1'b0, 64'h0);
      tick(); idle(); #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL evict_old_miss got=%b exp=0", pred_taken); end
      if_pc = 64'h140; #1;
      total++; if (pred_target !== 64'h148) begin bad++; $display("FAIL evict_new_target got=%h exp=148", pred_target); end
   endtask

   task automatic test_same_cycle();
      if_pc = 64'h300;
      drive_id(1'b1, 64'h300, 4'd5, 64'h0, 1'b0, 1'b0, 19'd8, 26'd0, 1'b0, 64'h0);
      #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL same_cycle_pred got=%b exp=0", pred_taken); end
      tick(); idle(); #1;
      total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL same_next_pred got=%b exp=1", pred_taken); end
      total++; if (pred_target !== 64'h320) begin bad++; $display("FAIL same_next_target got=%h exp=320", pred_target); end
   endtask

   task automatic test_reset_mid();
      if_pc = 64'h300;
      drive_id(1'b1, 64'h500, 4'd5, 64'h0, 1'b0, 1'b0, 19'd4, 26'd0, 1'b0, 64'h0);
      #1;
      reset = 1'b1;
      #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL rst_mid_immediate got=%b exp=0", pred_taken); end
      tick();
      reset = 1'b0; idle();
      if_pc = 64'h500; #1;
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL rst_mid_no_train got=%b exp=0", pred_taken); end
`ifdef BRPRED_STATS_EN
      total++; if (stat_branches !== 32'd0) begin bad++; $display("FAIL rst_mid_stat_br got=%0d exp=0", stat_branches); end
      total++; if (stat_mispredicts !== 32'd0) begin bad++; $display("FAIL rst_mid_stat_mp got=%0d exp=0", stat_mispredicts); end
      drive_id(1'b1, 64'h600, 4'd5, 64'h0, 1'b0, 1'b0, 19'd4, 26'd0, 1'b0, 64'h0);
      tick();
      drive_id(1'b1, 64'h600, 4'd1, 64'h0, 1'b0, 1'b0, 19'd4, 26'd0, 1'b0, 64'h0);
      tick(); idle(); #1;
      total++; if (stat_branches !== 32'd1) begin bad++; $display("FAIL stat_br_count got=%0d exp=1", stat_branches); end
      total++; if (stat_mispredicts !== 32'd1) begin bad++; $display("FAIL stat_mp_count got=%0d exp=1", stat_mispredicts); end
`endif
   endtask

   initial begin
      if_pc = 64'h0;
      test_reset();
      test_cbz_alloc();
      test_training();
      test_backward();
      test_uncond();
      test_id_invalid();
      test_wrap();
      test_alias();
      test_same_cycle();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
